if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, giving the bubble instruction presented when no valid fetch is held.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_id_wr  input  1  downstream IF/ID accept; 1 = output register consumed at this edge, 0 = stall.
REQ-006 redirect  input  1  branch/jump taken; one-cycle pulse, priority over all other events.
REQ-007 redirect_pc  input  32  redirect target.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  instruction memory word address.
REQ-010 imem_ack  input  1  memory response valid; meaningful only while imem_req=1.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 pc_plus4_out  output  32  registered PC+4 of the presented instruction, to IF/ID.
REQ-013 instr_out  output  32  registered instruction, to IF/ID.
REQ-014 if_valid  output  1  registered; 1 = instr_out/pc_plus4_out hold a real fetch.

Function
REQ-015 SHALL implement states FETCH, HOLD, DRAIN; imem_req=1 in FETCH and DRAIN, 0 in HOLD.
REQ-016 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ack=1; imem_ack with imem_req=0 SHALL be ignored.
REQ-017 In FETCH, imem_addr SHALL equal the internal pc register.
REQ-018 Output register SHALL be free when if_valid=0 or if_id_wr=1 in the same cycle.
REQ-019 FETCH, ack, no redirect, output free: instr_out<=imem_rdata, pc_plus4_out<=pc+4, if_valid<=1, pc<=pc+4, stay FETCH; back-to-back single-cycle acks SHALL sustain one instruction per cycle.
REQ-020 FETCH, ack, no redirect, output not free: imem_rdata and pc+4 captured in a one-entry skid buffer, pc<=pc+4, go HOLD.
REQ-021 HOLD, if_id_wr=1, no redirect: skid buffer moves to output register (if_valid stays 1), go FETCH.
REQ-022 HOLD, if_id_wr=0: all state and outputs unchanged.
REQ-023 Output consumed (if_id_wr=1, if_valid=1) with no new data loaded: if_valid<=0, instr_out<=NOP_INSTR, pc_plus4_out unchanged.
REQ-024 redirect=1 (any state): pc<={redirect_pc[31:2],2'b00}, skid buffer discarded, if_valid<=0, instr_out<=NOP_INSTR, regardless of if_id_wr.
REQ-025 redirect in FETCH without same-cycle ack: go DRAIN; imem_addr keeps the outstanding address.
REQ-026 redirect in FETCH with same-cycle ack: returned word discarded, stay FETCH at new pc next cycle.
REQ-027 redirect in HOLD: go FETCH.
REQ-028 DRAIN: on ack, data discarded, go FETCH; redirect in DRAIN updates pc to newest target, remains DRAIN unless ack same cycle (then FETCH).
REQ-029 pc+4 arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 No instruction SHALL be delivered twice, dropped (absent redirect), or reordered.

Reset
REQ-031 On rst: state FETCH, pc=RESET_PC, if_valid=0, instr_out=NOP_INSTR, pc_plus4_out=0, skid buffer empty.
REQ-032 First cycle after rst deassert: imem_req=1, imem_addr=RESET_PC.
REQ-033 rst mid-transaction (FETCH/DRAIN/HOLD) SHALL abandon the outstanding request; a late ack after reset is treated as response to the new RESET_PC request (bench keeps memory reset-coherent).

Verification
REQ-034 Streaming: ack every cycle, if_id_wr=1, rdata=addr^32'hA5A5_0000 -> instr_out sequence for 0,4,8,...; pc_plus4_out=4,8,12; if_valid=1 from cycle 2.
REQ-035 Stall: if_id_wr=0 for 3 cycles with ack -> one word in skid, imem_req=0 in HOLD, outputs frozen; on release both words delivered in order, none lost.
REQ-036 Redirect with outstanding request: ack delayed 3 cycles, redirect to 32'h0000_0100 -> DRAIN, stale word discarded, next imem_addr=32'h100, first delivered pc_plus4_out=32'h104.
REQ-037 Redirect+ack same cycle, redirect_pc=32'h0000_0203 -> word dropped, imem_addr=32'h200 next cycle, if_valid=0, instr_out=NOP_INSTR.
REQ-038 Wrap: RESET_PC=32'hFFFF_FFFC -> delivered pc_plus4_out=32'h0, next imem_addr=32'h0.
REQ-039 Async reset asserted in HOLD mid-cycle -> outputs reset immediately, not at next edge.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface if_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word requests, feeds the IF/ID register and
// absorbs one downstream stall cycle's worth of data in a one-entry skid buffer.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_id_wr,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   if_fetch_unit_if.master       imem,
   output logic [31:0]           pc_plus4_out,
   output logic [31:0]           instr_out,
   output logic                  if_valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;

   // Fetch-side state: PC, address of a request being drained, skid entry.
   logic [31:0] pc_p0, pc_p0_nxt;
   logic [31:0] drain_addr_p0, drain_addr_p0_nxt;
   logic [31:0] skid_instr_p0, skid_instr_p0_nxt;
   logic [31:0] skid_pc4_p0, skid_pc4_p0_nxt;

   // IF/ID-facing output register.
   logic [31:0] instr_p1, instr_p1_nxt;
   logic [31:0] pc4_p1, pc4_p1_nxt;
   logic        vld_p1, vld_p1_nxt;

   logic        out_free;
   logic        ack_seen;
   logic [31:0] pc_inc;
   logic [31:0] redirect_tgt;
   logic        unused_redirect_lsbs;

   // Word-aligned redirect target; the low two bits are deliberately dropped.
   assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Natural 32-bit add wraps 0xFFFF_FFFC to 0.
   assign pc_inc   = pc_p0 + 32'd4;
   assign out_free = !vld_p1 || if_id_wr;
   assign ack_seen = imem.imem_ack && imem.imem_req;

   assign imem.imem_req  = (state != HOLD);
   assign imem.imem_addr = (state == DRAIN) ? drain_addr_p0 : pc_p0;

   assign instr_out    = instr_p1;
   assign pc_plus4_out = pc4_p1;
   assign if_valid     = vld_p1;

   // State register and all datapath registers, async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FETCH;
         pc_p0         <= RESET_PC;
         drain_addr_p0 <= RESET_PC;
         skid_instr_p0 <= NOP_INSTR;
         skid_pc4_p0   <= 32'd0;
         instr_p1      <= NOP_INSTR;
         pc4_p1        <= 32'd0;
         vld_p1        <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc_p0         <= pc_p0_nxt;
         drain_addr_p0 <= drain_addr_p0_nxt;
         skid_instr_p0 <= skid_instr_p0_nxt;
         skid_pc4_p0   <= skid_pc4_p0_nxt;
         instr_p1      <= instr_p1_nxt;
         pc4_p1        <= pc4_p1_nxt;
         vld_p1        <= vld_p1_nxt;
      end
   end

   // Next-state and next-register values; redirect overrides everything else.
   always_comb begin
      state_nxt         = state;
      pc_p0_nxt         = pc_p0;
      drain_addr_p0_nxt = drain_addr_p0;
      skid_instr_p0_nxt = skid_instr_p0;
      skid_pc4_p0_nxt   = skid_pc4_p0;
      instr_p1_nxt      = instr_p1;
      pc4_p1_nxt        = pc4_p1;
      vld_p1_nxt        = vld_p1;

      if (redirect) begin
         pc_p0_nxt    = redirect_tgt;
         vld_p1_nxt   = 1'b0;
         instr_p1_nxt = NOP_INSTR;
         case (state)
            FETCH: begin
               if (ack_seen) begin
                  state_nxt = FETCH;
               end else begin
                  // Keep presenting the abandoned address until memory answers.
                  drain_addr_p0_nxt = pc_p0;
                  state_nxt         = DRAIN;
               end
            end
            HOLD:    state_nxt = FETCH;
            DRAIN:   state_nxt = ack_seen ? FETCH : DRAIN;
            default: state_nxt = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (ack_seen) begin
                  pc_p0_nxt = pc_inc;
                  if (out_free) begin
                     instr_p1_nxt = imem.imem_rdata;
                     pc4_p1_nxt   = pc_inc;
                     vld_p1_nxt   = 1'b1;
                  end else begin
                     skid_instr_p0_nxt = imem.imem_rdata;
                     skid_pc4_p0_nxt   = pc_inc;
                     state_nxt         = HOLD;
                  end
               end else if (vld_p1 && if_id_wr) begin
                  vld_p1_nxt   = 1'b0;
                  instr_p1_nxt = NOP_INSTR;
               end
            end
            HOLD: begin
               if (if_id_wr) begin
                  instr_p1_nxt = skid_instr_p0;
                  pc4_p1_nxt   = skid_pc4_p0;
                  vld_p1_nxt   = 1'b1;
                  state_nxt    = FETCH;
               end
            end
            DRAIN: begin
               if (ack_seen) begin
                  state_nxt = FETCH;
               end
               if (vld_p1 && if_id_wr) begin
                  vld_p1_nxt   = 1'b0;
                  instr_p1_nxt = NOP_INSTR;
               end
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule
